// File: rtl/nibble_serial_comparator.sv
// Sequential unsigned magnitude comparator: one 4-bit cascade slice, LSB nibble first,
// with registered gt/eq/lt fed back as the cascade inputs for the next nibble.
module nibble_serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rst_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic [3:0]       w_a_sel [NIB];
    logic [3:0]       w_b_sel [NIB];

    assign w_last = (r_idx == IDXW'(NIB - 1));

    // One-hot nibble select: each lane contributes only when idx points at it.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign w_a_sel[gi] = r_a[4*gi +: 4] & {4{r_idx == IDXW'(gi)}};
            assign w_b_sel[gi] = r_b[4*gi +: 4] & {4{r_idx == IDXW'(gi)}};
        end
    endgenerate

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            w_a_nib = w_a_nib | w_a_sel[i];
            w_b_nib = w_b_nib | w_b_sel[i];
        end
    end

    always_comb begin
        w_gt = r_gt;
        w_eq = r_eq;
        w_lt = r_lt;
        if (w_a_nib > w_b_nib) begin
            w_gt = 1'b1;
            w_eq = 1'b0;
            w_lt = 1'b0;
        end else if (w_a_nib < w_b_nib) begin
            w_gt = 1'b0;
            w_eq = 1'b0;
            w_lt = 1'b1;
        end
    end

    // in_ready is held low until one edge has seen rst_n released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_rst_done;
                if (in_valid && r_rst_done) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b1;
            r_lt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b1;
            r_lt  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_gt  <= w_gt;
            r_eq  <= w_eq;
            r_lt  <= w_lt;
            r_idx <= r_idx + 1'b1;
        end
    end

    assign out_gt = out_valid & r_gt;
    assign out_eq = out_valid & r_eq;
    assign out_lt = out_valid & r_lt;

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Directed and random checks of nibble_serial_comparator (WIDTH=16 and WIDTH=4)
// against a plain-arithmetic reference of unsigned compare and handshake timing.
module tb_nibble_serial_comparator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        out_gt, out_eq, out_lt, busy;
    logic [15:0] a, b;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic        out_gt4, out_eq4, out_lt4, busy4;
    logic [3:0]  a4, b4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_comparator #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .busy(busy)
    );

    nibble_serial_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_gt(out_gt4), .out_eq(out_eq4), .out_lt(out_lt4), .busy(busy4)
    );

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // Reference: {gt, eq, lt} of two unsigned numbers.
    function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
        return {x > y, x == y, x < y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=16 transaction; hold = cycles of out_ready=0 once out_valid is seen.
    task automatic run16(input logic [15:0] va, input logic [15:0] vb,
                         input int hold, input string tag);
        int n;
        logic [2:0] exp;
        exp = ref_cmp(va, vb);
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check(tag, "in_ready", in_ready, 1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        check(tag, "busy_run", busy, 1);
        check(tag, "in_ready_run", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            check(tag, "bits_idle", {out_gt, out_eq, out_lt}, 3'b000);
            tick();
            n++;
        end
        check(tag, "latency", n, 4);
        check(tag, "result", {out_gt, out_eq, out_lt}, exp);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
                tick();
                check(tag, "hold_valid", out_valid, 1);
                check(tag, "hold_result", {out_gt, out_eq, out_lt}, exp);
                check(tag, "hold_in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check(tag, "valid_drop", out_valid, 0);
        check(tag, "idle_ready", in_ready, 1);
        check(tag, "idle_busy", busy, 0);
        $display("[TB] %s a=%h b=%h hold=%0d exp=%b got_latency=%0d", tag, va, vb, hold, exp, n);
    endtask

    task automatic run4(input logic [3:0] va, input logic [3:0] vb, input string tag);
        int n;
        logic [2:0] exp;
        exp = ref_cmp(va, vb);
        out_ready4 = 1'b1;
        n = 0;
        while (!in_ready4 && n < 20) begin
            tick();
            n++;
        end
        check(tag, "in_ready", in_ready4, 1);
        a4 = va;
        b4 = vb;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        n = 0;
        while (!out_valid4 && n < 20) begin
            tick();
            n++;
        end
        check(tag, "latency", n, 1);
        check(tag, "result", {out_gt4, out_eq4, out_lt4}, exp);
        tick();
        check(tag, "valid_drop", out_valid4, 0);
        $display("[TB] %s a=%h b=%h exp=%b got_latency=%0d", tag, va, vb, exp, n);
    endtask

    logic [15:0] pa [3];
    logic [15:0] pb [3];
    int          acc [3];
    logic [15:0] ra, rb;
    logic        took;
    int          j, r, n, seen;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        check("reset", "out_valid", out_valid, 0);
        check("reset", "bits", {out_gt, out_eq, out_lt}, 3'b000);
        check("reset", "busy", busy, 0);
        check("reset", "in_ready", in_ready, 0);
        check("reset", "in_ready4", in_ready4, 0);
        rst_n = 1'b1;
        tick();
        check("reset", "ready_after", in_ready, 1);
        $display("[TB] reset released");

        run16(16'h1234, 16'h1234, 0, "equal");
        run16(16'h8000, 16'h7FFF, 0, "msb_override");
        run16(16'h0001, 16'h0002, 0, "lsb_carry");
        run16(16'hFFFF, 16'h0000, 0, "ones_vs_zeros");
        run16(16'h0000, 16'hFFFF, 0, "zeros_vs_ones");
        run16(16'h00A0, 16'h00B0, 5, "backpressure");

        // Reset two cycles into RUN discards the operation.
        out_ready = 1'b1;
        a = 16'h00F0; b = 16'h0010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midreset", "out_valid", out_valid, 0);
        check("midreset", "bits", {out_gt, out_eq, out_lt}, 3'b000);
        check("midreset", "busy", busy, 0);
        check("midreset", "in_ready_low", in_ready, 0);
        rst_n = 1'b1;
        check("midreset", "in_ready_unsampled", in_ready, 0);
        tick();
        check("midreset", "in_ready_up", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midreset", "no_result", seen, 0);
        $display("[TB] midreset aborted run, pulses_after=%0d", seen);

        // Back-to-back with in_valid held high.
        pa[0] = 16'h5A5A; pb[0] = 16'h5A5A;
        pa[1] = 16'h9000; pb[1] = 16'h8FFF;
        pa[2] = 16'h0102; pb[2] = 16'h0201;
        out_ready = 1'b1;
        j = 0; r = 0; n = 0;
        a = pa[0]; b = pb[0]; in_valid = 1'b1;
        while (r < 3 && n < 60) begin
            took = in_ready && in_valid;
            tick();
            n++;
            if (took) begin
                acc[j] = cyc;
                j++;
                if (j < 3) begin
                    a = pa[j]; b = pb[j];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b", "result", {out_gt, out_eq, out_lt}, ref_cmp(pa[r], pb[r]));
                $display("[TB] b2b result %0d a=%h b=%h got=%b", r, pa[r], pb[r], {out_gt, out_eq, out_lt});
                r++;
            end
        end
        in_valid = 1'b0;
        check("b2b", "count", r, 3);
        if (j == 3) begin
            check("b2b", "gap01", acc[1] - acc[0], 6);
            check("b2b", "gap12", acc[2] - acc[1], 6);
        end else begin
            check("b2b", "accepts", j, 3);
        end
        tick();

        run4(4'h3, 4'h9, "w4_lt");
        run4(4'hF, 4'h0, "w4_gt");
        run4(4'h7, 4'h7, "w4_eq");

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                default: rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            endcase
            run16(ra, rb, $urandom_range(0, 3), "rand16");
        end
        for (int i = 0; i < 8; i++) begin
            run4(4'($urandom), 4'($urandom), "rand4");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_comparator.md
# nibble_serial_comparator

- Sequential magnitude comparator for two WIDTH-bit unsigned words.
- Processes one 4-bit nibble per clock, LSB nibble first, through a single 4-bit cascade-compare slice.
- The slice's gt/eq/lt outputs are registered and fed back as its cascade inputs for the next, more significant nibble.
- Sits between a valid/ready word source and a valid/ready result consumer. It replaces a wide parallel comparator where area matters more than latency.

## Interface

- WIDTH, default 16: operand width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  source offers an operand pair.
- in_ready  output  1  block can accept a pair; high only in IDLE.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- out_gt  output  1  A > B.
- out_eq  output  1  A == B.
- out_lt  output  1  A < B.
- busy  output  1  high in RUN or DONE.

## Operation

**States.** Three states: IDLE, RUN, DONE. A nibble index idx runs 0..NIB-1.

**IDLE**
- in_ready=1.
- On in_valid & in_ready at an edge:
  - latch a and b into internal registers;
  - set cascade registers {gt,eq,lt} = {0,1,0};
  - set idx=0;
  - go to RUN.
- Otherwise stay in IDLE.

**RUN**
- Each edge compares nibble idx of the latched A and B (bits 4*idx+3 .. 4*idx) with cascade inputs taken from the cascade registers.
- Slice rule, applied per nibble:
  - A_nib > B_nib gives {1,0,0};
  - A_nib < B_nib gives {0,0,1};
  - A_nib == B_nib passes the cascade inputs through unchanged: gt from in_gt, eq from in_eq, lt from in_lt.
- The slice output is written back to the cascade registers and idx increments.
- The edge that processes idx=NIB-1 moves to DONE.

**DONE**
- out_valid=1.
- out_gt/out_eq/out_lt equal the cascade registers. Exactly one of the three is high.
- Outputs hold stable until out_valid & out_ready at an edge, then go to IDLE.

**Invariants**
- out_gt, out_eq, out_lt are all 0 whenever out_valid=0.
- in_valid is ignored outside IDLE.
- Changes on a/b after acceptance have no effect on the result in progress.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Timing

**Reset**
- While rst_n=0 at an edge: state goes to IDLE, idx=0, cascade={0,1,0}, operand registers cleared.
- Outputs during reset: out_valid=0, out_gt=out_eq=out_lt=0, busy=0, in_ready=0.
- in_ready rises the first cycle after rst_n is sampled high.

**Latency**
- Pair accepted at edge k.
- Nibbles are processed at edges k+1 .. k+NIB.
- out_valid is high from edge k+NIB. Latency is NIB cycles (4 for WIDTH=16).

**Throughput**
- If out_ready is already high, the result handshake completes at edge k+NIB+1 and the state returns to IDLE.
- The next pair can be accepted at edge k+NIB+2.
- Sustained rate is one compare per NIB+2 cycles.

**Boundary conditions**
- Backpressure: out_ready=0 in DONE holds out_valid and all result bits indefinitely; in_ready stays 0.
- Reset mid-operation (RUN or DONE): the operation is aborted and the result is discarded. No out_valid pulse follows reset.
- Equal operands: eq survives all NIB nibbles and gives {0,1,0}.
- WIDTH=4: a single RUN cycle; latency 1.
- All-ones vs all-zeros (both directions) must resolve correctly at the MSB nibble.

## Test plan

1. **Equal operands.** WIDTH=16, a=16'h1234, b=16'h1234, out_ready=1 -> out_valid 4 cycles after accept, out_eq=1, out_gt=out_lt=0, single-cycle out_valid.
2. **MSB nibble overrides lower nibbles.** a=16'h8000, b=16'h7FFF -> out_gt=1, even though the lower three nibbles compare as less-than.
3. **LSB decision carried through equal upper nibbles.** a=16'h0001, b=16'h0002 -> out_lt=1. Also a=16'hFFFF, b=16'h0000 -> out_gt=1.
4. **Backpressure.** a=16'h00A0, b=16'h00B0, out_ready=0 for 5 cycles after out_valid:
   - out_valid and out_lt=1 held for all 5 cycles;
   - in_ready=0 and a concurrent in_valid with new data is ignored;
   - raising out_ready returns to IDLE on the next edge.
5. **Reset mid-run.** rst_n=0 for one edge two cycles after accept -> next cycle IDLE with out_valid=0, all result bits 0, busy=0. No result appears afterwards; in_ready=1 once rst_n=1 has been sampled.
6. **Back-to-back pairs.** in_valid held high with three pairs (equal, greater, less), out_ready=1 -> accepts exactly 6 cycles apart, results eq, gt, lt in order. Repeat the less-than pair with WIDTH=4: a=4'h3, b=4'h9 -> out_lt=1, latency 1 cycle.
